ysyx_24100005_ifu: RTL and testbench

//   Instruction fetch unit, directly upstream of the single-cycle core.
//   - Owns the PC.
//   - Fetches one 32-bit word per instruction from instruction memory over a valid/ready request channel and a valid-only response channel.
//   - Holds the word plus its PC on a valid/ready output to the core.
//   - Advances to the next PC that the core returns in the same cycle it accepts the instruction.

---
 rtl/ysyx_24100005_ifu.sv | 89 ++++++++
 tb/tb_ysyx_24100005_ifu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction from imem,
// and presents {inst, inst_pc, inst_err} to the core until the core consumes it.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic [31:0] next_pc,
  output logic [31:0] inst_cnt,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are
  // both high; valid is never withdrawn and its payload never changes until then.
  // The response channel has no ready: imem_resp_valid is a one-cycle pulse.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_err_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Misaligned targets from the core are silently forced to a word boundary.
  assign pc_d  = next_pc & 32'hFFFF_FFFC;
  assign cnt_d = cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      inst_pc_q  <= 32'h0;
      inst_err_q <= 1'b0;
      cnt_q      <= 32'h0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            inst_q     <= imem_resp_err ? 32'h0 : imem_resp_data;
            inst_pc_q  <= pc_q;
            inst_err_q <= imem_resp_err;
            state_q    <= S_OUT;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // The request is held off while reset is asserted even though the state reads S_REQ.
  assign imem_req_valid = (state_q == S_REQ) && rst;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_err       = inst_err_q;
  assign inst_cnt       = cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for ysyx_24100005_ifu: a tiny memory driver answering one cycle
// after each request, a core driver that consumes with a chosen next_pc.
module tb_ysyx_24100005_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic [31:0] next_pc;
  logic [31:0] inst_cnt;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int out_cyc = 0;
  logic [31:0] exp_cnt = 32'h0;
  logic [31:0] exp_q[$];

  ysyx_24100005_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .next_pc(next_pc), .inst_cnt(inst_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // memory side: wait for request at exp_pc, fire it, answer one cycle later
  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data,
                          input logic err);
    int n = 0;
    imem_req_ready = 1'b1;
    while (!imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check("req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("req_addr", imem_req_addr, exp_pc);
    tick();
    check("wait_state", {30'h0, dbg_state}, 32'h1);
    check("req_drop", {31'h0, imem_req_valid}, 32'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    out_cyc = cyc;
    check("inst_valid", {31'h0, inst_valid}, 32'h1);
    check("inst", inst, err ? 32'h0 : data);
    check("inst_pc", inst_pc, exp_pc);
    check("inst_err", {31'h0, inst_err}, {31'h0, err});
  endtask

  // core side: consume the presented instruction
  task automatic do_consume(input logic [31:0] npc);
    inst_ready = 1'b1;
    next_pc    = npc;
    tick();
    inst_ready = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
    check("consumed", {31'h0, inst_valid}, 32'h0);
    check("inst_cnt", inst_cnt, exp_cnt);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] held_inst;
    logic [31:0] held_pc;
    int prev_out;
    rst = 1'b0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    imem_resp_err = 1'b0;
    inst_ready = 1'b0;
    next_pc = 32'h0;

    // 1: reset values, request right after release
    repeat (3) tick();
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_cnt", inst_cnt, 32'h0);
    rst = 1'b1;
    #1;
    check("rel_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("rel_req_addr", imem_req_addr, 32'h8000_0000);

    // 2: three sequential fetches, 3 cycles apart
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    exp_q.push_back(32'h8000_0008);
    prev_out = 0;
    for (int i = 0; i < 3; i++) begin
      pc = exp_q.pop_front();
      do_fetch(pc, 32'h0010_0093, 1'b0);
      if (i > 0) check("spacing", out_cyc - prev_out, 32'd3);
      prev_out = out_cyc;
      do_consume(pc + 32'd4);
    end
    check("cnt_after3", inst_cnt, 32'd3);

    // 3: stall in S_OUT for 10 cycles, with a stray response that must be ignored
    do_fetch(32'h8000_000C, 32'h1234_5678, 1'b0);
    held_inst = inst;
    held_pc   = inst_pc;
    for (int i = 0; i < 10; i++) begin
      imem_resp_valid = (i == 4);
      imem_resp_data  = 32'hCAFE_F00D;
      tick();
    end
    imem_resp_valid = 1'b0;
    check("stall_valid", {31'h0, inst_valid}, 32'h1);
    check("stall_inst", inst, 32'h1234_5678);
    check("stall_pc", inst_pc, 32'h8000_000C);
    check("stall_noreq", {31'h0, imem_req_valid}, 32'h0);
    check("stall_cnt", inst_cnt, 32'd3);

    // 4: misaligned next_pc is cleared
    do_consume(32'h8000_0102);
    check("misalign_addr", imem_req_addr, 32'h8000_0100);

    // 5: access fault presented like a normal instruction
    do_fetch(32'h8000_0100, 32'hDEAD_BEEF, 1'b1);
    do_consume(32'hFFFF_FFFF);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
    check("err_cleared", {31'h0, inst_err}, 32'h0);
    do_consume(32'h0000_0000);
    check("wrap_addr", imem_req_addr, 32'h0000_0000);

    // 6: reset while a response is outstanding, then a late pulse
    imem_req_ready = 1'b1;
    tick();
    check("in_wait", {30'h0, dbg_state}, 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'h0, imem_req_valid}, 32'h0);
    check("mid_rst_cnt", inst_cnt, 32'h0);
    tick();
    imem_req_ready  = 1'b0;
    rst = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    tick();
    imem_resp_valid = 1'b0;
    check("late_state", {30'h0, dbg_state}, 32'h0);
    check("late_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("late_inst", inst, 32'h0);
    check("late_cnt", inst_cnt, 32'h0);
    exp_cnt = 32'h0;
    do_fetch(32'h8000_0000, 32'h0000_0517, 1'b0);
    do_consume(32'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
